// File: rtl/phys_reg_free_list_if.sv
// Rename/commit port bundle of the physical register free list.
// The master side (rename + ROB commit) drives the requests; the slave side is the free list.
interface phys_reg_free_list_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          deq_req;
  logic          deq_valid;
  logic [7:0]    deq_reg;
  logic          enq_valid;
  logic [7:0]    enq_reg;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow_err;
  logic          underflow_err;

  modport master (
    output deq_req, enq_valid, enq_reg,
    input  deq_valid, deq_reg, count, full, overflow_err, underflow_err
  );

  modport slave (
    input  deq_req, enq_valid, enq_reg,
    output deq_valid, deq_reg, count, full, overflow_err, underflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register IDs: ROB commit pushes retired IDs,
// rename pops one per destination. Show-ahead read, no enqueue-to-dequeue bypass.
module phys_reg_free_list_chk #(
  parameter int NUM_PREGS = 64,
  parameter int DEPTH     = 32
)(
  input logic                       clk,
  input logic                       rst_n,
  input logic                       enq_valid,
  input logic [7:0]                 enq_reg,
  input logic [$clog2(DEPTH):0]     count
);
  // Returned IDs must name a real physical register
  enq_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    enq_valid |-> (enq_reg < 8'(NUM_PREGS)));

  // Occupancy can never exceed capacity
  count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    count <= ($clog2(DEPTH) + 1)'(DEPTH));
endmodule

module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS
)(
  input logic                 clk,
  input logic                 rst_n,
  phys_reg_free_list_if.slave fl
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    entry_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          full_r;
  logic          deq_valid_r;
  logic          overflow_r;
  logic          underflow_r;
  logic          pop_s;
  logic          udf_s;
  logic          enq_nz_s;
  logic          slot_s;
  logic          push_s;
  logic          ovf_s;

  // Decode push/pop legality and the next occupancy
  always_comb begin
    pop_s        = 1'b0;
    udf_s        = 1'b0;
    slot_s       = 1'b0;
    count_next_s = count_r;
    // p0 backs x0 and is never returned, so a zero ID is dropped silently
    enq_nz_s     = fl.enq_valid && (fl.enq_reg != 8'd0);
    if (deq_valid_r) begin
      pop_s = fl.deq_req;
      udf_s = 1'b0;
    end else begin
      pop_s = 1'b0;
      udf_s = fl.deq_req;
    end
    // When full, a same-cycle pop frees the head slot the push reuses
    if (full_r) begin
      slot_s = pop_s;
    end else begin
      slot_s = 1'b1;
    end
    push_s = enq_nz_s && slot_s;
    ovf_s  = enq_nz_s && !slot_s;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy, registered status flags and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= PW'(0);
      tail_r      <= PW'(0);
      count_r     <= CW'(DEPTH);
      full_r      <= 1'b1;
      deq_valid_r <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      head_r      <= pop_s  ? head_r + PW'(1) : head_r;
      tail_r      <= push_s ? tail_r + PW'(1) : tail_r;
      count_r     <= count_next_s;
      full_r      <= (count_next_s == CW'(DEPTH));
      deq_valid_r <= (count_next_s != CW'(0));
      overflow_r  <= overflow_r | ovf_s;
      underflow_r <= underflow_r | udf_s;
    end
  end

  // Entry storage, preloaded with every ID above the identity-mapped ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= 8'(NUM_AREGS + i);
      end
    end else if (push_s) begin
      entry_r[tail_r] <= fl.enq_reg;
    end
  end

  assign fl.deq_reg       = entry_r[head_r];
  assign fl.deq_valid     = deq_valid_r;
  assign fl.count         = count_r;
  assign fl.full          = full_r;
  assign fl.overflow_err  = overflow_r;
  assign fl.underflow_err = underflow_r;

  phys_reg_free_list_chk #(
    .NUM_PREGS (NUM_PREGS),
    .DEPTH     (DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_valid (fl.enq_valid),
    .enq_reg   (fl.enq_reg),
    .count     (count_r)
  );
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: stimulus queues expected pop IDs,
// a negedge monitor compares every pop the DUT actually performs.
module tb_phys_reg_free_list;
  logic clk;
  logic rst_n;

  phys_reg_free_list_if #(.DEPTH(32)) fl ();

  phys_reg_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl)
  );

  int total = 0;
  int bad   = 0;

  int exp_q[$];      // expected deq_reg for each issued pop
  int model_q[$];    // free IDs the list should hold, head first
  bit m_ovf;
  bit m_udf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every real pop must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && fl.deq_req && fl.deq_valid) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(fl.deq_reg), 32'hFFFF_FFFF);
      end else begin
        check("pop_id", 32'(fl.deq_reg), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_q.push_back(32 + i);
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},     32'(fl.count),         32'(model_q.size()));
    check({tag, "_full"},      32'(fl.full),          32'(model_q.size() == 32));
    check({tag, "_deq_valid"}, 32'(fl.deq_valid),     32'(model_q.size() != 0));
    check({tag, "_ovf"},       32'(fl.overflow_err),  32'(m_ovf));
    check({tag, "_udf"},       32'(fl.underflow_err), 32'(m_udf));
  endtask

  task automatic check_reset_image(input string tag);
    check({tag, "_deq_valid"}, 32'(fl.deq_valid),     32'd1);
    check({tag, "_deq_reg"},   32'(fl.deq_reg),       32'd32);
    check({tag, "_count"},     32'(fl.count),         32'd32);
    check({tag, "_full"},      32'(fl.full),          32'd1);
    check({tag, "_ovf"},       32'(fl.overflow_err),  32'd0);
    check({tag, "_udf"},       32'(fl.underflow_err), 32'd0);
  endtask

  // Called at posedge+1; returns at the next posedge+1
  task automatic do_reset();
    fl.deq_req   = 1'b0;
    fl.enq_valid = 1'b0;
    fl.enq_reg   = 8'd0;
    rst_n        = 1'b0;
    model_reset();
    #2;
    check_reset_image("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit deq, input bit ev, input logic [7:0] er);
    bit pop;
    bit nz;
    bit slot;
    bit pre_valid;
    pre_valid = (model_q.size() != 0);
    pop  = deq && pre_valid;
    nz   = ev && (er != 8'd0);
    slot = (model_q.size() < 32) || pop;
    fl.deq_req   = deq;
    fl.enq_valid = ev;
    fl.enq_reg   = er;
    if (pop) exp_q.push_back(model_q.pop_front());
    if (deq && !pop) m_udf = 1'b1;
    if (nz && slot) model_q.push_back(int'(er));
    if (nz && !slot) m_ovf = 1'b1;
    #2;
    // deq_valid must reflect state only, never the enqueue presented this cycle
    check("no_bypass_valid", 32'(fl.deq_valid), 32'(pre_valid));
    @(posedge clk);
    #1;
    check_state("step");
  endtask

  initial begin
    rst_n        = 1'b0;
    fl.deq_req   = 1'b0;
    fl.enq_valid = 1'b0;
    fl.enq_reg   = 8'd0;
    @(posedge clk);
    #1;

    // Drain the reset image: 32..63 in order
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("drain_count", 32'(fl.count), 32'd0);
    check("drain_valid", 32'(fl.deq_valid), 32'd0);
    check("drain_udf", 32'(fl.underflow_err), 32'd0);
    check("drain_left", 32'(exp_q.size()), 32'd0);

    // Underflow from empty is sticky
    step(1'b1, 1'b0, 8'd0);
    check("udf_set", 32'(fl.underflow_err), 32'd1);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("udf_sticky", 32'(fl.underflow_err), 32'd1);
    check("udf_count", 32'(fl.count), 32'd0);

    // Push into full list without a pop overflows
    do_reset();
    step(1'b0, 1'b1, 8'd40);
    check("ovf_set", 32'(fl.overflow_err), 32'd1);
    check("ovf_count", 32'(fl.count), 32'd32);

    // Same push with a pop is accepted; 40 comes out after 33..63
    do_reset();
    step(1'b1, 1'b1, 8'd40);
    check("full_swap_ovf", 32'(fl.overflow_err), 32'd0);
    check("full_swap_count", 32'(fl.count), 32'd32);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 8'd0);
    check("full_swap_head", 32'(fl.deq_reg), 32'd40);
    step(1'b1, 1'b0, 8'd0);
    check("full_swap_left", 32'(exp_q.size()), 32'd0);

    // From empty: push 5,17,9 with concurrent pops, no bypass
    step(1'b1, 1'b1, 8'd5);
    check("bypass_udf", 32'(fl.underflow_err), 32'd1);
    check("bypass_head5", 32'(fl.deq_reg), 32'd5);
    step(1'b1, 1'b1, 8'd17);
    step(1'b1, 1'b1, 8'd9);
    step(1'b1, 1'b0, 8'd0);
    check("bypass_count", 32'(fl.count), 32'd0);
    check("bypass_left", 32'(exp_q.size()), 32'd0);

    // Wrap: pop 20, push 20, then 32 pops with random pushes
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(i + 1));
    check("wrap_full", 32'(fl.full), 32'd1);
    for (int i = 0; i < 32; i++) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 63)));
    while (model_q.size() != 0) step(1'b1, 1'b0, 8'd0);
    check("wrap_left", 32'(exp_q.size()), 32'd0);
    check("wrap_ovf", 32'(fl.overflow_err), 32'd0);

    // Zero ID is ignored, both below capacity and at capacity
    do_reset();
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd0);
    check("zero_count", 32'(fl.count), 32'd31);
    step(1'b0, 1'b1, 8'd7);
    step(1'b0, 1'b1, 8'd0);
    check("zero_full_ovf", 32'(fl.overflow_err), 32'd0);

    // Asynchronous reset mid-stream returns to the reset image
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd12);
    fl.deq_req   = 1'b1;
    fl.enq_valid = 1'b1;
    fl.enq_reg   = 8'd13;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_image("async_rst");
    fl.deq_req   = 1'b0;
    fl.enq_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'd0);
    check("post_rst_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
